// File: rtl/uart_tx_arbiter_if.sv
// Bus between the round-robin UART arbiter, its byte producers and the shared transmitter.
// The arbiter uses the master view; clients and the transmitter use the slave view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               timeout;
  logic               busy;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;

  modport master (
    input  req, req_data, tx_done,
    output gnt, done, timeout, busy, tx_start, tx_data
  );

  modport slave (
    output req, req_data, tx_done,
    input  gnt, done, timeout, busy, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter between N_REQ byte producers,
// with a saturating watchdog that abandons a transfer whose tx_done never arrives.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 131072
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_arbiter_if.master    bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Returns {found, index}: the first set request searching upward from ptr+1, wrapping.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0] pick;
    logic [PTR_W:0] idx;
    pick = {(PTR_W+1){1'b0}};
    // Walk from the farthest candidate to the nearest so the nearest one overwrites.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_REQ)) begin
        idx = idx - (PTR_W+1)'(N_REQ);
      end else begin
        idx = idx;
      end
      if (req[idx[PTR_W-1:0]]) begin
        pick = {1'b1, idx[PTR_W-1:0]};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [7:0] byte_at(input logic [8*N_REQ-1:0] data,
                                         input logic [PTR_W-1:0]   idx);
    logic [8*N_REQ-1:0] shifted;
    shifted = data >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

  state_t             state_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   sel_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [N_REQ-1:0]   gnt_r;
  logic [N_REQ-1:0]   done_r;
  logic               timeout_r;
  logic               busy_r;
  logic               tx_start_r;
  logic [7:0]         tx_data_r;
  logic [PTR_W:0]     pick_s;

  // Candidate requester for the next grant.
  always_comb begin
    pick_s = rr_pick(bus.req, ptr_r);
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= PTR_RST;
      sel_r      <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      gnt_r      <= {N_REQ{1'b0}};
      done_r     <= {N_REQ{1'b0}};
      timeout_r  <= 1'b0;
      busy_r     <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r    <= {N_REQ{1'b0}};
          timeout_r <= 1'b0;
          if (pick_s[PTR_W]) begin
            sel_r      <= pick_s[PTR_W-1:0];
            gnt_r      <= onehot(pick_s[PTR_W-1:0]);
            tx_data_r  <= byte_at(bus.req_data, pick_s[PTR_W-1:0]);
            tx_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_START;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_START: begin
          tx_start_r <= 1'b0;
          cnt_r      <= {CNT_W{1'b0}};
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          // tx_done is checked first so it wins over a watchdog expiry in the same cycle.
          if (bus.tx_done) begin
            done_r  <= onehot(sel_r);
            ptr_r   <= sel_r;
            gnt_r   <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (cnt_r == CNT_LAST) begin
            timeout_r <= 1'b1;
            ptr_r     <= sel_r;
            gnt_r     <= {N_REQ{1'b0}};
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt_r      <= {N_REQ{1'b0}};
          done_r     <= {N_REQ{1'b0}};
          timeout_r  <= 1'b0;
          busy_r     <= 1'b0;
          tx_start_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.timeout  = timeout_r;
  assign bus.busy     = busy_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;

endmodule
